// File: rtl/nobl_sram_model_pkg.sv
// Shared types for the NoBL/ZBT SRAM responder: operation codes, the
// pipeline-stage record and the linear-burst helper.
package nobl_pkg;

    localparam int BURST_BITS = 2;
    localparam int ADDR_MAX   = 32;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2
    } op_e;

    // Address is carried at a fixed maximum width; users slice the low bits.
    typedef struct packed {
        op_e                 op;
        logic [ADDR_MAX-1:0] addr;
    } stage_t;

    localparam stage_t STAGE_NOP = '{op: OP_NOP, addr: '0};

    // Low address bits of a linear burst: base plus offset, wrapping mod 4.
    function automatic logic [BURST_BITS-1:0] burst_lo(
        input logic [BURST_BITS-1:0] base_lo,
        input logic [BURST_BITS-1:0] offs
    );
        return base_lo + offs;
    endfunction

endpackage

// File: rtl/nobl_sram_model_if.sv
// RAM_* pin bundle between the FIFO controller (master) and the SRAM (slave).
interface nobl_sram_model_if #(
    parameter int WIDTH     = 18,
    parameter int RAM_DEPTH = 19
);
    logic [WIDTH-1:0]     RAM_D_po;
    logic                 RAM_D_poe;
    logic [WIDTH-1:0]     RAM_D_pi;
    logic                 RAM_D_oe;
    logic [RAM_DEPTH-1:0] RAM_A;
    logic                 RAM_WEn;
    logic                 RAM_CENn;
    logic                 RAM_LDn;
    logic                 RAM_OEn;
    logic                 RAM_CE1n;

    modport master (
        output RAM_D_po, RAM_D_poe, RAM_A, RAM_WEn, RAM_CENn, RAM_LDn,
               RAM_OEn, RAM_CE1n,
        input  RAM_D_pi, RAM_D_oe
    );

    modport slave (
        input  RAM_D_po, RAM_D_poe, RAM_A, RAM_WEn, RAM_CENn, RAM_LDn,
               RAM_OEn, RAM_CE1n,
        output RAM_D_pi, RAM_D_oe
    );
endinterface

// File: rtl/nobl_sram_model_burst_addr.sv
// Command decode and linear burst address generator. Produces the
// {op, addr} pair the pipeline captures at the current clock edge.
//
// last_op_q  | meaning
// -----------+--------------------------------------------------
// OP_NOP     | no burst open; ADVANCE decodes as NOP
// OP_READ    | read burst open; ADVANCE reads base + offset
// OP_WRITE   | write burst open; ADVANCE writes base + offset
module nobl_burst_addr
    import nobl_pkg::*;
#(
    parameter int RAM_DEPTH = 19
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cen_n_i,
    input  logic                 ld_n_i,
    input  logic                 ce1_n_i,
    input  logic                 we_n_i,
    input  logic [RAM_DEPTH-1:0] addr_i,
    output stage_t               cmd_o
);

    logic [RAM_DEPTH-1:0]  base_q, base_d;
    logic [BURST_BITS-1:0] cnt_q, cnt_d;
    op_e                   last_op_q, last_op_d;
    op_e                   cur_op;
    logic [RAM_DEPTH-1:0]  cur_addr;

    // Decode the bus command; loads restart the burst, advances step the offset.
    always_comb begin
        base_d    = base_q;
        cnt_d     = cnt_q;
        last_op_d = last_op_q;
        cur_op    = OP_NOP;
        cur_addr  = base_q;
        if (!cen_n_i) begin
            if (!ld_n_i) begin
                if (ce1_n_i) begin
                    last_op_d = OP_NOP;
                end else begin
                    cur_op    = we_n_i ? OP_READ : OP_WRITE;
                    cur_addr  = addr_i;
                    base_d    = addr_i;
                    cnt_d     = BURST_BITS'(1);
                    last_op_d = cur_op;
                end
            end else if (last_op_q != OP_NOP) begin
                cur_op   = last_op_q;
                cur_addr = {base_q[RAM_DEPTH-1:BURST_BITS],
                            burst_lo(base_q[BURST_BITS-1:0], cnt_q)};
                cnt_d    = cnt_q + BURST_BITS'(1);
            end
        end
    end

    // Burst state registers; a stall leaves everything untouched via the hold defaults.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q    <= '0;
            cnt_q     <= '0;
            last_op_q <= OP_NOP;
        end else begin
            base_q    <= base_d;
            cnt_q     <= cnt_d;
            last_op_q <= last_op_d;
        end
    end

    assign cmd_o = '{op: cur_op, addr: ADDR_MAX'(cur_addr)};

endmodule

// File: rtl/nobl_sram_model.sv
// Cycle-accurate NoBL/ZBT pipelined SRAM responder: two-stage late-write /
// pipelined-read pipeline, internal array, read register, completion
// counters and a sticky bus-contention flag.
module nobl_sram_model
    import nobl_pkg::*;
#(
    parameter int WIDTH     = 18,
    parameter int RAM_DEPTH = 19
) (
    input  logic               clk,
    input  logic               rst,
    nobl_sram_model_if.slave   bus,
    output logic               contention_err,
    output logic [31:0]        rd_count,
    output logic [31:0]        wr_count
);

    stage_t               cmd;
    stage_t               stage1_q, stage1_d;
    stage_t               stage2_q, stage2_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0]     d_pi_q, d_pi_d;
    logic                 cont_q, cont_d;
    logic [31:0]          rd_cnt_q, rd_cnt_d;
    logic [31:0]          wr_cnt_q, wr_cnt_d;
    logic                 mem_we;
    logic [RAM_DEPTH-1:0] mem_addr;
    logic [WIDTH-1:0]     rd_data;
    logic                 oe;
    logic                 unused_addr_hi;

    logic [WIDTH-1:0]     mem [0:(1<<RAM_DEPTH)-1];

    nobl_burst_addr #(.RAM_DEPTH(RAM_DEPTH)) u_burst (
        .clk     (clk),
        .rst     (rst),
        .cen_n_i (bus.RAM_CENn),
        .ld_n_i  (bus.RAM_LDn),
        .ce1_n_i (bus.RAM_CE1n),
        .we_n_i  (bus.RAM_WEn),
        .addr_i  (bus.RAM_A),
        .cmd_o   (cmd)
    );

    assign mem_addr       = stage2_q.addr[RAM_DEPTH-1:0];
    assign rd_data        = mem[mem_addr];
    assign unused_addr_hi = ^stage2_q.addr[ADDR_MAX-1:RAM_DEPTH];
    assign oe             = rd_valid_q & ~bus.RAM_OEn;

    // Advance the pipeline and execute the stage-2 op on every enabled edge.
    always_comb begin
        stage1_d   = stage1_q;
        stage2_d   = stage2_q;
        rd_valid_d = rd_valid_q;
        d_pi_d     = d_pi_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        cont_d     = cont_q;
        mem_we     = 1'b0;
        if (!bus.RAM_CENn) begin
            stage1_d = cmd;
            stage2_d = stage1_q;
            case (stage2_q.op)
                OP_WRITE: begin
                    mem_we     = 1'b1;
                    wr_cnt_d   = wr_cnt_q + 32'd1;
                    rd_valid_d = 1'b0;
                end
                OP_READ: begin
                    d_pi_d     = rd_data;
                    rd_valid_d = 1'b1;
                    rd_cnt_d   = rd_cnt_q + 32'd1;
                end
                default: rd_valid_d = 1'b0;
            endcase
        end
        // Contention is sampled on every edge, stalled or not.
        if (oe && bus.RAM_D_poe) begin
            cont_d = 1'b1;
        end
    end

    // Pipeline, read register, counters and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage1_q   <= STAGE_NOP;
            stage2_q   <= STAGE_NOP;
            rd_valid_q <= 1'b0;
            d_pi_q     <= '0;
            cont_q     <= 1'b0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
        end else begin
            stage1_q   <= stage1_d;
            stage2_q   <= stage2_d;
            rd_valid_q <= rd_valid_d;
            d_pi_q     <= d_pi_d;
            cont_q     <= cont_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    // Array write; contents survive reset but a reset edge never commits a write.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_addr] <= bus.RAM_D_po;
        end
    end

    assign bus.RAM_D_pi  = d_pi_q;
    assign bus.RAM_D_oe  = oe;
    assign contention_err = cont_q;
    assign rd_count       = rd_cnt_q;
    assign wr_count       = wr_cnt_q;

endmodule

// File: tb/tb_nobl_sram_model.sv
// Bench for nobl_sram_model: table-driven bus cycles with a scoreboard of
// pending reads/writes keyed by the enabled edge on which they complete.
module tb_nobl_sram_model;

    localparam int W = 18;
    localparam int D = 10;
    localparam int K_NOP = 0;
    localparam int K_RD  = 1;
    localparam int K_WR  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        contention_err;
    logic [31:0] rd_count;
    logic [31:0] wr_count;

    always #5 clk = ~clk;

    nobl_sram_model_if #(.WIDTH(W), .RAM_DEPTH(D)) bus ();

    nobl_sram_model #(.WIDTH(W), .RAM_DEPTH(D)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .contention_err (contention_err),
        .rd_count       (rd_count),
        .wr_count       (wr_count)
    );

    typedef struct {
        string        nm;
        logic         cen_n;
        logic         ld_n;
        logic         ce1_n;
        logic         we_n;
        logic [D-1:0] a;
        int           kind;   // op this cycle is expected to issue
        logic [W-1:0] data;   // write data, or the word the read must return
        logic         oen;
        logic         poe;
    } vec_t;

    typedef struct {
        int           due;
        logic [W-1:0] data;
    } pend_t;

    pend_t        rdq[$];
    pend_t        wrq[$];
    vec_t         tbl[$];
    int           tests = 0;
    int           fails = 0;
    int           act = 0;
    logic         exp_valid = 1'b0;
    logic [W-1:0] exp_pi = '0;
    logic         exp_cont = 1'b0;
    int           exp_rd = 0;
    int           exp_wr = 0;
    logic [W-1:0] idle_po = 18'h2AAAA;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", nm, got, want);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic cen_n, input logic ld_n,
                                input logic ce1_n, input logic we_n, input logic [D-1:0] a,
                                input int kind, input logic [W-1:0] d,
                                input logic oen, input logic poe);
        vec_t v;
        v.nm = nm; v.cen_n = cen_n; v.ld_n = ld_n; v.ce1_n = ce1_n; v.we_n = we_n;
        v.a = a; v.kind = kind; v.data = d; v.oen = oen; v.poe = poe;
        return v;
    endfunction

    function automatic vec_t wr(input string nm, input logic [D-1:0] a, input logic [W-1:0] d);
        return mk(nm, 1'b0, 1'b0, 1'b0, 1'b0, a, K_WR, d, 1'b0, 1'b0);
    endfunction

    function automatic vec_t rd(input string nm, input logic [D-1:0] a, input logic [W-1:0] d);
        return mk(nm, 1'b0, 1'b0, 1'b0, 1'b1, a, K_RD, d, 1'b0, 1'b0);
    endfunction

    // ADVANCE drives a stray address, CE1n=1 and the opposite WEn: all must be ignored.
    function automatic vec_t adv(input string nm, input int kind, input logic [W-1:0] d);
        return mk(nm, 1'b0, 1'b1, 1'b1, (kind == K_WR), 10'h3FF, kind, d, 1'b0, 1'b0);
    endfunction

    // Deselect with WEn=0 and a live address: must not write.
    function automatic vec_t nop(input string nm);
        return mk(nm, 1'b0, 1'b0, 1'b1, 1'b0, 10'h020, K_NOP, '0, 1'b0, 1'b0);
    endfunction

    // Stall carrying a write load that must be ignored.
    function automatic vec_t stall(input string nm);
        return mk(nm, 1'b1, 1'b0, 1'b0, 1'b0, 10'h020, K_NOP, '0, 1'b0, 1'b0);
    endfunction

    task automatic step(input vec_t v);
        logic pre_oe;
        bus.RAM_CENn  = v.cen_n;
        bus.RAM_LDn   = v.ld_n;
        bus.RAM_CE1n  = v.ce1_n;
        bus.RAM_WEn   = v.we_n;
        bus.RAM_A     = v.a;
        bus.RAM_OEn   = v.oen;
        bus.RAM_D_poe = v.poe;
        bus.RAM_D_po  = (wrq.size() > 0 && wrq[0].due == act + 1) ? wrq[0].data
                                                                   : idle_po ^ W'(act);
        pre_oe = exp_valid & ~v.oen;
        if (!v.cen_n && v.kind == K_RD) rdq.push_back('{due: act + 3, data: v.data});
        if (!v.cen_n && v.kind == K_WR) wrq.push_back('{due: act + 3, data: v.data});
        @(posedge clk);
        if (pre_oe && v.poe) exp_cont = 1'b1;
        if (!v.cen_n) begin
            act++;
            if (wrq.size() > 0 && wrq[0].due == act) begin
                wrq.delete(0);
                exp_wr++;
            end
            if (rdq.size() > 0 && rdq[0].due == act) begin
                exp_pi    = rdq[0].data;
                exp_valid = 1'b1;
                rdq.delete(0);
                exp_rd++;
            end else begin
                exp_valid = 1'b0;
            end
        end
        #1;
        check({v.nm, " oe"}, 64'(bus.RAM_D_oe), 64'(exp_valid & ~v.oen));
        if (exp_valid) check({v.nm, " pi"}, 64'(bus.RAM_D_pi), 64'(exp_pi));
        check({v.nm, " contention"}, 64'(contention_err), 64'(exp_cont));
    endtask

    task automatic run_tbl();
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
        tbl.delete();
    endtask

    task automatic check_counts(input string nm);
        check({nm, " rd_count"}, 64'(rd_count), 64'(exp_rd));
        check({nm, " wr_count"}, 64'(wr_count), 64'(exp_wr));
    endtask

    task automatic apply_reset(input logic [W-1:0] po);
        rst           = 1'b1;
        bus.RAM_CENn  = 1'b0;
        bus.RAM_LDn   = 1'b0;
        bus.RAM_CE1n  = 1'b1;
        bus.RAM_WEn   = 1'b1;
        bus.RAM_A     = '0;
        bus.RAM_OEn   = 1'b0;
        bus.RAM_D_poe = 1'b0;
        bus.RAM_D_po  = po;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdq.delete();
        wrq.delete();
        exp_valid = 1'b0;
        exp_pi    = '0;
        exp_cont  = 1'b0;
        exp_rd    = 0;
        exp_wr    = 0;
        check("reset oe", 64'(bus.RAM_D_oe), 64'd0);
        check("reset pi", 64'(bus.RAM_D_pi), 64'd0);
        check("reset contention", 64'(contention_err), 64'd0);
        check_counts("reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        apply_reset(18'h00000);

        // Single write then read: output only on edge n+6.
        tbl.push_back(wr("w010", 10'h010, 18'h3A5A5));
        for (int i = 0; i < 3; i++) tbl.push_back(nop("gap1"));
        tbl.push_back(rd("r010", 10'h010, 18'h3A5A5));
        for (int i = 0; i < 3; i++) tbl.push_back(nop("lat1"));
        run_tbl();
        check_counts("single");

        // Write burst from 0x012 wraps within the 4-word block; read back as a burst and singly.
        tbl.push_back(wr ("bw0", 10'h012, 18'd1));
        tbl.push_back(adv("bw1", K_WR, 18'd2));
        tbl.push_back(adv("bw2", K_WR, 18'd3));
        tbl.push_back(adv("bw3", K_WR, 18'd4));
        tbl.push_back(nop("bgap"));
        tbl.push_back(rd ("br0", 10'h012, 18'd1));
        tbl.push_back(adv("br1", K_RD, 18'd2));
        tbl.push_back(adv("br2", K_RD, 18'd3));
        tbl.push_back(adv("br3", K_RD, 18'd4));
        tbl.push_back(rd ("s010", 10'h010, 18'd3));
        tbl.push_back(rd ("s011", 10'h011, 18'd4));
        tbl.push_back(rd ("s013", 10'h013, 18'd2));
        tbl.push_back(nop("bdsel"));
        tbl.push_back(adv("adv_after_dsel", K_NOP, 18'd0));
        for (int i = 0; i < 3; i++) tbl.push_back(nop("btail"));
        run_tbl();
        check_counts("burst");

        // Back-to-back W/R on 0x020: every read sees the write one cycle earlier.
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(wr("alt_w", 10'h020, 18'h100 + 18'(i)));
            tbl.push_back(rd("alt_r", 10'h020, 18'h100 + 18'(i)));
        end
        for (int i = 0; i < 3; i++) tbl.push_back(nop("alt_tail"));
        run_tbl();
        check_counts("alternate");

        // Three stall edges mid read burst; stalls carry a write load that must be dropped.
        tbl.push_back(rd ("st_r0", 10'h012, 18'd1));
        tbl.push_back(adv("st_r1", K_RD, 18'd2));
        tbl.push_back(adv("st_r2", K_RD, 18'd3));
        for (int i = 0; i < 3; i++) tbl.push_back(stall("st_hold"));
        tbl.push_back(adv("st_r3", K_RD, 18'd4));
        for (int i = 0; i < 3; i++) tbl.push_back(nop("st_tail"));
        // Write in flight across a stall commits the right data exactly once.
        tbl.push_back(wr("stw", 10'h040, 18'h11111));
        tbl.push_back(stall("stw_hold"));
        tbl.push_back(stall("stw_hold"));
        tbl.push_back(nop("stw_gap"));
        tbl.push_back(rd("stw_r", 10'h040, 18'h11111));
        tbl.push_back(rd("st_r020", 10'h020, 18'h107));
        for (int i = 0; i < 3; i++) tbl.push_back(nop("stw_tail"));
        run_tbl();
        check_counts("stall");

        // OEn=1 masks the driver; then controller drives while model drives.
        tbl.push_back(rd("oen_r", 10'h010, 18'd3));
        tbl.push_back(nop("oen_gap"));
        tbl.push_back(mk("oen_due", 1'b0, 1'b0, 1'b1, 1'b1, 10'h0, K_NOP, '0, 1'b1, 1'b1));
        tbl.push_back(nop("oen_after"));
        tbl.push_back(rd("ct_r", 10'h011, 18'd4));
        tbl.push_back(nop("ct_gap"));
        tbl.push_back(nop("ct_due"));
        tbl.push_back(mk("ct_clash", 1'b0, 1'b0, 1'b1, 1'b1, 10'h0, K_NOP, '0, 1'b0, 1'b1));
        tbl.push_back(wr("ct_w030", 10'h030, 18'h0BEEF));
        for (int i = 0; i < 3; i++) tbl.push_back(nop("ct_sticky"));
        run_tbl();
        check_counts("contention");

        // Reset one cycle after a write command: the write never reaches the array.
        idle_po = 18'h3FFFF;
        step(wr("rst_w", 10'h030, 18'h3FFFF));
        apply_reset(18'h3FFFF);
        tbl.push_back(nop("post_rst"));
        tbl.push_back(adv("adv_after_rst", K_NOP, 18'd0));
        tbl.push_back(nop("post_rst2"));
        tbl.push_back(rd("rst_r030", 10'h030, 18'h0BEEF));
        for (int i = 0; i < 3; i++) tbl.push_back(nop("rst_tail"));
        run_tbl();
        check_counts("post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nobl_sram_model.md
# nobl_sram_model

Synthesizable, cycle-accurate responder for the pipelined ZBT/NoBL SRAM bus driven by the external-FIFO controller. It is the device end of the RAM_* pins: it decodes LDn/WEn/CE1n/CENn, runs a 2-deep late-write/pipelined-read pipeline with a linear burst counter, stores data in an internal array, and flags bus contention. It is used in benches and loopback builds in place of the off-chip SRAM.

## Interface
- WIDTH, 18: data bus width.
- RAM_DEPTH, 19: address width; array holds 2**RAM_DEPTH words (benches use 10).
- clk  in  1  device clock (the controller's ext_clk).
- rst  in  1  synchronous, active-high reset.
- RAM_D_po  in  WIDTH  write data from controller.
- RAM_D_poe  in  1  controller drives the data bus.
- RAM_D_pi  out  WIDTH  read data to controller.
- RAM_D_oe  out  1  model drives the data bus.
- RAM_A  in  RAM_DEPTH  address.
- RAM_WEn, RAM_CENn, RAM_LDn, RAM_OEn, RAM_CE1n  in  1 each  active-low write, clock enable, load, output enable, chip select.
- contention_err  out  1  sticky: both sides drove the bus.
- rd_count, wr_count  out  32 each  completed reads/writes.

## Operation
- Command decode at each clk edge with RAM_CENn=0:
  - LDn=0, CE1n=1: DESELECT (NOP).
  - LDn=0, CE1n=0: load base address RAM_A; op = WRITE if WEn=0 else READ.
  - LDn=1: ADVANCE; repeat previous op type at base with A[1:0] incremented mod 4 (linear burst, upper bits fixed). ADVANCE after DESELECT or reset is NOP.
- RAM_CENn=1: full stall; commands ignored, pipeline, burst counter, read register and RAM_D_oe state hold; no array write.
- Pipeline: stage1 captures {op, addr} at command edge n; stage2 at n+1; stage2 op acts at n+2:
  - WRITE: mem[addr] <= RAM_D_po; wr_count++.
  - READ: RAM_D_pi <= mem[addr]; read-valid <= 1; rd_count++.
  - NOP: read-valid <= 0.
- RAM_D_oe = read-valid & ~RAM_OEn (OEn combinational, no pipeline).
- contention_err set at any edge with RAM_D_oe & RAM_D_poe; cleared only by rst.
- Counters wrap at 2**32.
- Reset: stage1/stage2 = NOP, burst counter cleared, read-valid=0, RAM_D_oe=0, RAM_D_pi=0, contention_err=0, counters=0. Array contents not cleared. Reset mid-burst discards in-flight ops (no write commits).

## Timing
- Read latency 2: command at edge n -> RAM_D_pi valid from edge n+2 to n+3.
- Write data sampled at edge n+2 for a write command at edge n.
- No turnaround cycles: W,R,W,R back-to-back at full rate.
- Coherency: write at edge n followed by read of same address at n+1 returns new data (commit at n+2, read at n+3); no forwarding needed.
- Stall cycles extend latency by exactly the number of CENn=1 edges.

## Structure
- Package nobl_pkg: op enum {NOP, READ, WRITE}, pipeline-stage struct {op, addr}, BURST_BITS=2.
- Sub-module nobl_burst_addr: base register, 2-bit linear counter, last-op/selected state, outputs current {op, addr}.
- Top: decode, two stage registers, array, read register, counters, contention flag.

## Test plan
- Write 0x3A5A5 to 0x010 at edge n, data at n+2; read 0x010 at n+4 -> RAM_D_pi=0x3A5A5, RAM_D_oe=1 from edge n+6 only.
- Load write 0x012, 3 ADVANCEs, data 1..4 -> mem[0x012,0x013,0x010,0x011]=1,2,3,4 (wrap within 4); burst read back in same order.
- Alternating W/R every cycle on 0x020 with incrementing data -> each read returns prior write, wr_count=rd_count=N.
- Hold RAM_CENn=1 for 3 cycles mid-read-burst -> output held, data arrives 3 cycles late, no lost/duplicated words.
- Read with RAM_OEn=1 -> RAM_D_oe=0; read while controller sets RAM_D_poe=1 -> contention_err=1 until rst.
- Assert rst one cycle after write command -> no array update, all outputs at reset values next edge.
